// File: rtl/crc_rr_arbiter.sv
// Packet-level round-robin arbiter driving the one-hot select of the CRC datapath mux.
// Optional stall watchdog is compiled in with `define CRC_ARB_TIMEOUT_EN.
module crc_rr_arbiter #(
  parameter int PORTS   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PORTS-1:0] s_valid_i,
  input  logic [PORTS-1:0] s_last_i,
  output logic [PORTS-1:0] s_ready_o,
  output logic [PORTS-1:0] sel_o,
  output logic             m_valid_o,
  output logic             m_last_o,
  input  logic             m_ready_i,
  output logic             busy_o,
  output logic             timeout_o
);

  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam logic [PORTS-1:0] ONE = PORTS'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_reg, state_next;
  logic [PORTS-1:0] sel_reg, sel_next;
  logic [PW-1:0]    ptr_reg, ptr_next;
  logic [PORTS-1:0] mask_hi, req_hi, pick;
  logic [PW-1:0]    gidx, ptr_adv;
  logic             accept;
  logic             timeout;

`ifdef CRC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_reg, cnt_next;
`endif

  // Sources at or above the pointer win; otherwise fall back to the lowest index (wrap).
  genvar gi;
  generate
    for (gi = 0; gi < PORTS; gi++) begin : g_mask
      assign mask_hi[gi] = (ptr_reg <= PW'(gi));
    end
  endgenerate

  assign req_hi = s_valid_i & mask_hi;
  assign pick   = (|req_hi) ? (req_hi & (~req_hi + ONE))
                            : (s_valid_i & (~s_valid_i + ONE));

  always_comb begin
    gidx = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (sel_reg[i]) gidx = PW'(i);
    end
  end

  assign ptr_adv = (gidx == PW'(PORTS - 1)) ? '0 : gidx + PW'(1);

  assign sel_o     = sel_reg;
  assign s_ready_o = sel_reg & {PORTS{m_ready_i}};
  assign m_valid_o = |(s_valid_i & sel_reg);
  assign m_last_o  = |(s_last_i & sel_reg);
  assign busy_o    = (state_reg == BUSY);
  assign timeout_o = timeout;
  assign accept    = m_valid_o & m_ready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
      ptr_reg   <= '0;
`ifdef CRC_ARB_TIMEOUT_EN
      cnt_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      ptr_reg   <= ptr_next;
`ifdef CRC_ARB_TIMEOUT_EN
      cnt_reg   <= cnt_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    ptr_next   = ptr_reg;
    timeout    = 1'b0;
`ifdef CRC_ARB_TIMEOUT_EN
    cnt_next   = cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (|s_valid_i) begin
          sel_next   = pick;
          state_next = BUSY;
`ifdef CRC_ARB_TIMEOUT_EN
          cnt_next   = '0;
`endif
        end
      end
      BUSY: begin
        if (accept && m_last_o) begin
          sel_next   = '0;
          state_next = IDLE;
          ptr_next   = ptr_adv;
`ifdef CRC_ARB_TIMEOUT_EN
          cnt_next   = '0;
`endif
        end
`ifdef CRC_ARB_TIMEOUT_EN
        else if (!m_valid_o) begin
          // The stall that would bring the count to TIMEOUT is the release cycle.
          if (cnt_reg == CW'(TIMEOUT - 1)) begin
            timeout    = 1'b1;
            sel_next   = '0;
            state_next = IDLE;
            ptr_next   = ptr_adv;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end else begin
          cnt_next = '0;
        end
`endif
      end
      default: begin
        state_next = IDLE;
        sel_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_crc_rr_arbiter.sv
// Directed bench for crc_rr_arbiter: reset, round robin, lock/back-pressure, wrap, stall handling.
module tb_crc_rr_arbiter;

  localparam int PORTS   = 4;
  localparam int TIMEOUT = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [PORTS-1:0] s_valid = '0;
  logic [PORTS-1:0] s_last = '0;
  logic [PORTS-1:0] s_ready;
  logic [PORTS-1:0] sel;
  logic             m_valid;
  logic             m_last;
  logic             m_ready = 1'b1;
  logic             busy;
  logic             timeout;

  int checks_cnt = 0;
  int errors_cnt = 0;

  crc_rr_arbiter #(.PORTS(PORTS), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid_i (s_valid),
    .s_last_i  (s_last),
    .s_ready_o (s_ready),
    .sel_o     (sel),
    .m_valid_o (m_valid),
    .m_last_o  (m_last),
    .m_ready_i (m_ready),
    .busy_o    (busy),
    .timeout_o (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: %0h (t=%0t)", tag, obs, $time);
    end
  endtask

  // Drive one cycle of inputs mid-cycle and settle before any checks.
  task automatic step(input logic r, input logic [PORTS-1:0] v, input logic [PORTS-1:0] l,
                      input logic rdy);
    @(negedge clk);
    rst_n   = r;
    s_valid = v;
    s_last  = l;
    m_ready = rdy;
    #1;
  endtask

  logic [PORTS-1:0] rr_order [5];

  initial begin
    rr_order[0] = 4'b0001;
    rr_order[1] = 4'b0010;
    rr_order[2] = 4'b0100;
    rr_order[3] = 4'b1000;
    rr_order[4] = 4'b0001;

    // Reset held with every source requesting
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b1111, 4'b0000, 1'b1);
      check("rst_sel", 32'(sel), 32'h0);
      check("rst_mvalid", 32'(m_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_sready", 32'(s_ready), 32'h0);
      check("rst_timeout", 32'(timeout), 32'h0);
    end
    step(1'b1, 4'b1111, 4'b0000, 1'b1);
    check("rel_sel", 32'(sel), 32'h0);

    // Continuous 2-beat packets from all sources
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 4'b1111, ~rr_order[k], 1'b1);
      check("rr_sel_b1", 32'(sel), 32'(rr_order[k]));
      check("rr_busy", 32'(busy), 32'h1);
      check("rr_mlast_b1", 32'(m_last), 32'h0);
      check("rr_sready", 32'(s_ready), 32'(rr_order[k]));
      step(1'b1, 4'b1111, rr_order[k], 1'b1);
      check("rr_sel_b2", 32'(sel), 32'(rr_order[k]));
      check("rr_mlast_b2", 32'(m_last), 32'h1);
      step(1'b1, (k == 4) ? 4'b0000 : 4'b1111, 4'b0000, 1'b1);
      check("rr_bubble_sel", 32'(sel), 32'h0);
      check("rr_bubble_busy", 32'(busy), 32'h0);
    end

    // Idle with nothing requesting, then source 2 alone
    step(1'b1, 4'b0000, 4'b0000, 1'b1);
    check("idle_sel", 32'(sel), 32'h0);
    step(1'b1, 4'b0100, 4'b0000, 1'b1);
    check("req_latency_sel", 32'(sel), 32'h0);

    // Lock and back-pressure; source 0 joins mid-packet
    step(1'b1, 4'b0100, 4'b0000, 1'b1);
    check("lk1_sel", 32'(sel), 32'h4);
    check("lk1_sready", 32'(s_ready), 32'h4);
    check("lk1_mvalid", 32'(m_valid), 32'h1);
    step(1'b1, 4'b0101, 4'b0100, 1'b0);
    check("lk2_sel", 32'(sel), 32'h4);
    check("lk2_sready", 32'(s_ready), 32'h0);
    check("lk2_mlast", 32'(m_last), 32'h1);
    step(1'b1, 4'b0101, 4'b0100, 1'b0);
    check("lk3_sel", 32'(sel), 32'h4);
    check("lk3_sready", 32'(s_ready), 32'h0);
    step(1'b1, 4'b0101, 4'b0100, 1'b1);
    check("lk4_sel", 32'(sel), 32'h4);
    check("lk4_sready", 32'(s_ready), 32'h4);
    step(1'b1, 4'b0010, 4'b0000, 1'b1);
    check("lk_bubble_sel", 32'(sel), 32'h0);

    // Pointer at 3, only source 1 valid: wraps to 1, pointer becomes 2
    step(1'b1, 4'b0010, 4'b0010, 1'b1);
    check("wrap1_sel", 32'(sel), 32'h2);
    step(1'b1, 4'b1010, 4'b0000, 1'b1);
    check("wrap1_bubble", 32'(sel), 32'h0);

    // Sources 3 and 1 with pointer at 2
    step(1'b1, 4'b1010, 4'b1000, 1'b1);
    check("skip_sel3", 32'(sel), 32'h8);
    step(1'b1, 4'b1010, 4'b0000, 1'b1);
    check("skip_bubble1", 32'(sel), 32'h0);
    step(1'b1, 4'b1010, 4'b0010, 1'b1);
    check("skip_sel1", 32'(sel), 32'h2);
    step(1'b1, 4'b1111, 4'b0000, 1'b1);
    check("skip_bubble2", 32'(sel), 32'h0);
    step(1'b1, 4'b1111, 4'b0100, 1'b1);
    check("ptr_is_2_sel", 32'(sel), 32'h4);
    step(1'b1, 4'b0010, 4'b0000, 1'b1);
    check("pre_to_bubble", 32'(sel), 32'h0);

    // Source 1 sends one non-last beat then goes silent
    step(1'b1, 4'b0010, 4'b0000, 1'b1);
    check("to_beat_sel", 32'(sel), 32'h2);
`ifdef CRC_ARB_TIMEOUT_EN
    for (int s = 1; s <= TIMEOUT; s++) begin
      step(1'b1, 4'b0000, 4'b0000, 1'b1);
      check("to_stall_sel", 32'(sel), 32'h2);
      check("to_stall_pulse", 32'(timeout), (s == TIMEOUT) ? 32'h1 : 32'h0);
    end
    step(1'b1, 4'b1111, 4'b0000, 1'b1);
    check("to_release_sel", 32'(sel), 32'h0);
    check("to_release_busy", 32'(busy), 32'h0);
    check("to_release_pulse", 32'(timeout), 32'h0);
    step(1'b1, 4'b1111, 4'b0000, 1'b1);
    check("to_next_grant", 32'(sel), 32'h4);
`else
    for (int s = 0; s < 100; s++) begin
      step(1'b1, 4'b0000, 4'b0000, 1'b1);
      check("lock_hold_sel", 32'(sel), 32'h2);
      check("lock_hold_to", 32'(timeout), 32'h0);
    end
`endif

    // Reset mid-packet aborts the grant and clears the pointer
    step(1'b0, 4'b1111, 4'b0000, 1'b1);
    step(1'b1, 4'b1111, 4'b0000, 1'b1);
    check("midrst_sel", 32'(sel), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    step(1'b1, 4'b1111, 4'b0000, 1'b1);
    check("midrst_regrant", 32'(sel), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
